// File: rtl/baud_gen_frac.sv
// rtl/baud_gen_frac.sv - fractional baud tick generator (oversample, mid-bit and end-of-bit ticks)
// A phase accumulator adds BAUD*OS per enabled edge and wraps at FRE, so the average tick rate is exact.
module baud_gen_frac #(
  parameter int FRE   = 40_000_000,
  parameter int BAUD0 = 9600,
  parameter int BAUD1 = 19200,
  parameter int BAUD2 = 57600,
  parameter int BAUD3 = 115200,
  parameter int OS    = 16,
  parameter int ACC_W = $clog2(FRE) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       resync,
  input  logic [1:0] baud_sel,
  output logic       tick_os,
  output logic       tick_mid,
  output logic       tick_bit,
  output logic [1:0] baud_act
);

  localparam int INC0 = BAUD0 * OS;
  localparam int INC1 = BAUD1 * OS;
  localparam int INC2 = BAUD2 * OS;
  localparam int INC3 = BAUD3 * OS;
  localparam int OS_W = $clog2(OS);

  localparam logic [ACC_W-1:0] FRE_A    = ACC_W'(FRE);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OS / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS - 1);

  generate
    if (FRE < 2 * INC0 || FRE < 2 * INC1 || FRE < 2 * INC2 || FRE < 2 * INC3) begin : g_bad_rate
      $error("baud_gen_frac: FRE must be at least twice every BAUDn*OS");
    end
    if (OS < 4 || (OS % 2) != 0) begin : g_bad_os
      $error("baud_gen_frac: OS must be even and at least 4");
    end
  endgenerate

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc_sel;
  logic [ACC_W-1:0] sum;
  logic [OS_W-1:0]  os_cnt;
  logic             wrap;
  logic             os_last;

  always_comb begin
    inc_sel = ACC_W'(INC0);
    case (baud_act)
      2'd0: inc_sel = ACC_W'(INC0);
      2'd1: inc_sel = ACC_W'(INC1);
      2'd2: inc_sel = ACC_W'(INC2);
      2'd3: inc_sel = ACC_W'(INC3);
      default: inc_sel = ACC_W'(INC0);
    endcase
  end

  assign sum     = acc + inc_sel;
  assign wrap    = (sum >= FRE_A);
  assign os_last = (os_cnt == OS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      baud_act <= 2'd0;
    end else if (resync) begin
      acc      <= '0;
      os_cnt   <= '0;
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      baud_act <= baud_sel;
    end else if (!en) begin
      tick_os  <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      baud_act <= baud_sel;
    end else begin
      acc      <= wrap ? (sum - FRE_A) : sum;
      tick_os  <= wrap;
      tick_mid <= wrap && (os_cnt == OS_MID);
      tick_bit <= wrap && os_last;
      if (wrap) begin
        os_cnt <= os_last ? '0 : os_cnt + OS_W'(1);
      end
      // Rate switches only on a bit boundary so a bit never mixes two rates.
      if (wrap && os_last) begin
        baud_act <= baud_sel;
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb/tb_baud_gen_frac.sv - randomized and directed bench for baud_gen_frac against a total-phase model
module tb_baud_gen_frac;

  localparam int FRE = 64;
  localparam int OS  = 4;
  localparam int BAUD [4] = '{1, 2, 3, 5};

  logic       clk;
  logic       rst;
  logic       en;
  logic       resync;
  logic [1:0] baud_sel;
  logic       tick_os;
  logic       tick_mid;
  logic       tick_bit;
  logic [1:0] baud_act;

  baud_gen_frac #(
    .FRE(FRE), .BAUD0(1), .BAUD1(2), .BAUD2(3), .BAUD3(5), .OS(OS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .baud_sel(baud_sel),
    .tick_os(tick_os), .tick_mid(tick_mid), .tick_bit(tick_bit), .baud_act(baud_act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: total phase since restart; a tick happens whenever phase crosses a multiple of FRE.
  longint m_phase = 0;
  int     m_ticks = 0;
  int     m_act   = 0;
  bit     m_os, m_mid, m_bit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    longint inc;
    bit t;
    m_os = 0; m_mid = 0; m_bit = 0;
    if (rst) begin
      m_phase = 0; m_ticks = 0; m_act = 0;
    end else if (resync) begin
      m_phase = 0; m_ticks = 0; m_act = int'(baud_sel);
    end else if (!en) begin
      m_act = int'(baud_sel);
    end else begin
      inc = longint'(BAUD[m_act] * OS);
      t = ((m_phase + inc) / FRE) > (m_phase / FRE);
      m_phase += inc;
      if (t) begin
        m_ticks++;
        m_os  = 1;
        m_mid = (m_ticks % OS) == OS / 2;
        m_bit = (m_ticks % OS) == 0;
        if (m_bit) m_act = int'(baud_sel);
      end
    end
  endtask

  function automatic bit next_is_bit();
    longint inc;
    inc = longint'(BAUD[m_act] * OS);
    return (((m_phase + inc) / FRE) > (m_phase / FRE)) && (((m_ticks + 1) % OS) == 0);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tick_os",  32'(tick_os),  32'(m_os));
    check("tick_mid", 32'(tick_mid), 32'(m_mid));
    check("tick_bit", 32'(tick_bit), 32'(m_bit));
    check("baud_act", 32'(baud_act), 32'(m_act));
  endtask

  task automatic do_resync(input logic [1:0] sel);
    resync = 1'b1; baud_sel = sel;
    cycle();
    resync = 1'b0;
  endtask

  int cnt;
  int k;
  bit found;

  initial begin
    rst = 1'b1; en = 1'b0; resync = 1'b0; baud_sel = 2'd0;
    cycle();
    cycle();
    rst = 1'b0; en = 1'b1;

    // Integer ratio: 16 cycles per tick, 10 ticks in 160 edges
    cnt = 0;
    repeat (160) begin cycle(); cnt += int'(tick_os); end
    check("avg_sel0", cnt, 10);

    // Fractional ratio 64/12: exactly 36 ticks in 192 edges
    do_resync(2'd2);
    cnt = 0;
    repeat (192) begin cycle(); cnt += int'(tick_os); end
    check("avg_sel2", cnt, 36);

    // Resync alignment: first tick_mid 32 cycles later, tick_bit at 64
    do_resync(2'd0);
    found = 0;
    for (k = 1; k <= 100 && !found; k++) begin
      cycle();
      if (tick_mid) begin found = 1; check("resync_mid_delay", k, 32); end
    end
    if (!found) check("resync_mid_timeout", 0, 1);
    found = 0;
    for (k = 33; k <= 100 && !found; k++) begin
      cycle();
      if (tick_bit) begin found = 1; check("resync_bit_delay", k, 64); end
    end
    if (!found) check("resync_bit_timeout", 0, 1);

    // Rate switch mid-bit: stays 0 until tick_bit, then spacing becomes 8
    do_resync(2'd0);
    repeat (20) cycle();
    baud_sel = 2'd1;
    found = 0;
    for (k = 0; k < 100 && !found; k++) begin
      cycle();
      if (tick_bit) found = 1;
      else check("switch_hold", 32'(baud_act), 32'd0);
    end
    if (!found) check("switch_timeout", 0, 1);
    check("switch_act", 32'(baud_act), 32'd1);
    found = 0;
    for (k = 1; k <= 40 && !found; k++) begin
      cycle();
      if (tick_os) begin found = 1; check("switch_spacing", k, 8); end
    end
    if (!found) check("switch_spacing_timeout", 0, 1);

    // Resync landing exactly on the tick_bit edge
    repeat (3) begin
      baud_sel = 2'($urandom_range(0, 3));
      found = 0;
      for (k = 0; k < 300 && !found; k++) begin
        if (next_is_bit()) begin
          found = 1;
          do_resync(baud_sel);
          check("resync_on_bit_os", 32'(tick_os), 32'd0);
        end else begin
          cycle();
        end
      end
      if (!found) check("resync_on_bit_timeout", 0, 1);
    end

    // en low 7 cycles mid-bit: phase resumes where it left off
    do_resync(2'd0);
    repeat (10) cycle();
    en = 1'b0;
    repeat (7) begin cycle(); check("en_low_quiet", 32'(tick_os), 32'd0); end
    en = 1'b1;
    found = 0;
    for (k = 1; k <= 40 && !found; k++) begin
      cycle();
      if (tick_os) begin found = 1; check("en_resume_delay", k, 6); end
    end
    if (!found) check("en_resume_timeout", 0, 1);

    // Reset mid-bit
    baud_sel = 2'd3;
    repeat (9) cycle();
    rst = 1'b1;
    cycle();
    check("rst_act", 32'(baud_act), 32'd0);
    check("rst_os", 32'(tick_os), 32'd0);
    rst = 1'b0;

    // Random traffic
    repeat (4000) begin
      rst      = ($urandom_range(0, 199) == 0);
      resync   = ($urandom_range(0, 59) == 0);
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) baud_sel = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
